// File: rtl/calc_hex_display.sv
// calc_hex_display
//   Captures an 8-bit result word on a load strobe and shows it on one
//   7-segment output. The display repeats this sequence: high nibble,
//   blank, low nibble, blank.
//
// Parameters
//   DWELL    cycles each digit is shown (1..65535)
//   GAP      blank cycles after each digit (0..65535; 0 drops the blank phases)
//
// Ports
//   clock    sole clock, rising edge
//   Reset    asynchronous active-low reset
//   Value    result word, sampled only while Load=1
//   Load     capture strobe, level-sampled every edge
//   Clear    synchronous return to idle, overrides Load
//   SegOut   bits[6:0] = segments g..a (active high), bit 7 = decimal point
//   DigitSel 2'b10 high digit, 2'b01 low digit, 2'b00 blank/idle
module calc_hex_display #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] Value,
  input  logic       Load,
  input  logic       Clear,
  output logic [7:0] SegOut,
  output logic [1:0] DigitSel
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_GAP1 = 3'd2,
    ST_LO   = 3'd3,
    ST_GAP2 = 3'd4
  } state_t;

  // Terminal counts for each phase. GAP_LAST is guarded so that GAP=0
  // cannot underflow. The gap states are never entered in that case.
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 32'd1);
  localparam logic [15:0] GAP_LAST   = (GAP == 32'd0) ? 16'd0 : 16'(GAP - 32'd1);
  localparam logic        NO_GAP     = (GAP == 32'd0);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [7:0]  held_r;

  // Hex nibble to segments g..a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg_v;
    case (nib)
      4'h0:    seg_v = 7'h3F;
      4'h1:    seg_v = 7'h06;
      4'h2:    seg_v = 7'h5B;
      4'h3:    seg_v = 7'h4F;
      4'h4:    seg_v = 7'h66;
      4'h5:    seg_v = 7'h6D;
      4'h6:    seg_v = 7'h7D;
      4'h7:    seg_v = 7'h07;
      4'h8:    seg_v = 7'h7F;
      4'h9:    seg_v = 7'h6F;
      4'hA:    seg_v = 7'h77;
      4'hB:    seg_v = 7'h7C;
      4'hC:    seg_v = 7'h39;
      4'hD:    seg_v = 7'h5E;
      4'hE:    seg_v = 7'h79;
      4'hF:    seg_v = 7'h71;
      default: seg_v = 7'h00;
    endcase
    return seg_v;
  endfunction

  // Output word {SegOut, DigitSel} for a given state and held value.
  // The decimal point marks the high digit.
  function automatic logic [9:0] disp(input state_t st, input logic [7:0] held);
    logic [9:0] d_v;
    case (st)
      ST_HI:   d_v = {1'b1, seg7(held[7:4]), 2'b10};
      ST_LO:   d_v = {1'b0, seg7(held[3:0]), 2'b01};
      default: d_v = 10'h000;
    endcase
    return d_v;
  endfunction

  // Sequencer: state, dwell counter, held value and registered outputs.
  // Outputs are loaded from the state being entered. This makes a new
  // phase appear on the same edge that enters it.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_r              <= ST_IDLE;
      cnt_r                <= 16'd0;
      held_r               <= 8'h00;
      {SegOut, DigitSel}   <= 10'h000;
    end else if (Clear) begin
      state_r              <= ST_IDLE;
      cnt_r                <= 16'd0;
      {SegOut, DigitSel}   <= 10'h000;
    end else if (Load) begin
      held_r               <= Value;
      state_r              <= ST_HI;
      cnt_r                <= 16'd0;
      {SegOut, DigitSel}   <= disp(ST_HI, Value);
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r              <= 16'd0;
          {SegOut, DigitSel} <= 10'h000;
        end
        ST_HI: begin
          if (cnt_r == DWELL_LAST) begin
            cnt_r <= 16'd0;
            if (NO_GAP) begin
              state_r            <= ST_LO;
              {SegOut, DigitSel} <= disp(ST_LO, held_r);
            end else begin
              state_r            <= ST_GAP1;
              {SegOut, DigitSel} <= 10'h000;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_GAP1: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r              <= 16'd0;
            state_r            <= ST_LO;
            {SegOut, DigitSel} <= disp(ST_LO, held_r);
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_LO: begin
          if (cnt_r == DWELL_LAST) begin
            cnt_r <= 16'd0;
            if (NO_GAP) begin
              state_r            <= ST_HI;
              {SegOut, DigitSel} <= disp(ST_HI, held_r);
            end else begin
              state_r            <= ST_GAP2;
              {SegOut, DigitSel} <= 10'h000;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_GAP2: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r              <= 16'd0;
            state_r            <= ST_HI;
            {SegOut, DigitSel} <= disp(ST_HI, held_r);
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r            <= ST_IDLE;
          cnt_r              <= 16'd0;
          {SegOut, DigitSel} <= 10'h000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_hex_display.sv
// Testbench for calc_hex_display.
// dut_a uses the default parameters (DWELL=4, GAP=2).
// dut_b uses DWELL=1, GAP=0.
// Expected display words are pushed to a queue when stimulus is driven.
// They are popped and compared one cycle later, when the DUT output is valid.
module tb_calc_hex_display;

  logic       clock;
  logic       Reset;
  logic [7:0] value_a, value_b;
  logic       load_a, load_b, clear_a, clear_b;
  logic [7:0] seg_a, seg_b;
  logic [1:0] sel_a, sel_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];

  logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  calc_hex_display dut_a (
    .clock(clock), .Reset(Reset), .Value(value_a), .Load(load_a), .Clear(clear_a),
    .SegOut(seg_a), .DigitSel(sel_a)
  );

  calc_hex_display #(.DWELL(1), .GAP(0)) dut_b (
    .clock(clock), .Reset(Reset), .Value(value_b), .Load(load_b), .Clear(clear_b),
    .SegOut(seg_b), .DigitSel(sel_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compares one observed value against its expected value.
  // Counts the comparison and reports any mismatch.
  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got seg=%h sel=%b, expected seg=%h sel=%b at %0t",
               tag, obs[9:2], obs[1:0], expv[9:2], expv[1:0], $time);
    end
  endtask

  // Expected {SegOut, DigitSel} t cycles after a load edge.
  // It is derived from the loop timing alone.
  function automatic logic [9:0] exp_at(input int t, input logic [7:0] v,
                                        input int dwell, input int gap);
    int p;
    p = t % (2 * (dwell + gap));
    if (p < dwell)                  return {1'b1, seg_tab[v[7:4]], 2'b10};
    else if (p < dwell + gap)       return 10'h000;
    else if (p < 2 * dwell + gap)   return {1'b0, seg_tab[v[3:0]], 2'b01};
    else                            return 10'h000;
  endfunction

  task automatic step_a(input logic ld, input logic clr, input logic [7:0] v,
                        input logic [9:0] expv, input string tag);
    @(negedge clock);
    load_a = ld; clear_a = clr; value_a = v;
    exp_q_a.push_back(expv);
    @(posedge clock);
    #1;
    check(tag, {seg_a, sel_a}, exp_q_a.pop_front());
  endtask

  task automatic step_b(input logic ld, input logic [7:0] v,
                        input logic [9:0] expv, input string tag);
    @(negedge clock);
    load_b = ld; value_b = v;
    exp_q_b.push_back(expv);
    @(posedge clock);
    #1;
    check(tag, {seg_b, sel_b}, exp_q_b.pop_front());
  endtask

  initial begin
    logic [7:0] v;
    Reset = 1'b0;
    load_a = 1'b0; clear_a = 1'b0; value_a = 8'h00;
    load_b = 1'b0; clear_b = 1'b0; value_b = 8'h00;
    #1;
    check("reset_a", {seg_a, sel_a}, 10'h000);
    check("reset_b", {seg_b, sel_b}, 10'h000);
    @(negedge clock);
    Reset = 1'b1;

    // Idle after reset. Value changes without Load have no effect.
    for (int i = 0; i < 20; i++) step_a(1'b0, 1'b0, 8'($urandom), 10'h000, "idle");

    // Single-cycle load of 3A, then more than two full periods.
    // The run ends in the LO phase.
    step_a(1'b1, 1'b0, 8'h3A, {8'hCF, 2'b10}, "load_3A");
    for (int t = 1; t < 32; t++)
      step_a(1'b0, 1'b0, 8'($urandom), exp_at(t, 8'h3A, 4, 2), "run_3A");

    // Load during LO restarts at HI with the new value.
    step_a(1'b1, 1'b0, 8'hF0, {8'hF1, 2'b10}, "midlo_F0");
    for (int t = 1; t < 8; t++)
      step_a(1'b0, 1'b0, 8'($urandom), exp_at(t, 8'hF0, 4, 2), "run_F0");

    // Clear wins over a same-cycle Load. A later Load alone shows ED.
    step_a(1'b1, 1'b1, 8'h55, 10'h000, "load_clear");
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 8'h55, 10'h000, "after_clear");
    step_a(1'b1, 1'b0, 8'h55, {8'hED, 2'b10}, "load_55");
    for (int t = 1; t < 6; t++)
      step_a(1'b0, 1'b0, 8'h55, exp_at(t, 8'h55, 4, 2), "run_55");

    // Reset pulse during GAP1. The outputs must clear before any edge.
    step_a(1'b1, 1'b0, 8'h3A, {8'hCF, 2'b10}, "load_3A_b");
    for (int t = 1; t < 5; t++)
      step_a(1'b0, 1'b0, 8'h3A, exp_at(t, 8'h3A, 4, 2), "to_gap1");
    step_a(1'b0, 1'b0, 8'h3A, exp_at(5, 8'h3A, 4, 2), "in_gap1");
    #2 Reset = 1'b0;
    #1 check("async_reset", {seg_a, sel_a}, 10'h000);
    @(negedge clock);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 8'($urandom), 10'h000, "idle_after_rst");

    // Load held high: recaptures every cycle and stays on the high digit.
    v = 8'h00;
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      step_a(1'b1, 1'b0, v, exp_at(0, v, 4, 2), "load_held");
    end
    for (int t = 1; t < 13; t++)
      step_a(1'b0, 1'b0, 8'($urandom), exp_at(t, v, 4, 2), "after_held");

    // DWELL=1, GAP=0 alternates HI/LO every cycle.
    step_b(1'b1, 8'h09, {8'hBF, 2'b10}, "b_load_09");
    for (int t = 1; t < 9; t++)
      step_b(1'b0, 8'($urandom), exp_at(t, 8'h09, 1, 0), "b_alt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
